// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide coprocessor.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_MULL = 2'd0,
        OP_MULH = 2'd1,
        OP_DIV  = 2'd2,
        OP_MOD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Divide-family ops share the high op bit.
    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] shreg_next,
    output logic             q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum        = acc + {1'b0, operand};
        shifted    = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        trial      = shifted - {1'b0, operand};
        acc_next   = acc;
        shreg_next = shreg;
        q_bit      = 1'b0;
        if (is_div) begin
            // Remainder stays below the divisor, so trial[WIDTH] is exactly the borrow.
            q_bit      = ~trial[WIDTH];
            acc_next   = q_bit ? trial : shifted;
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end else if (shreg[0]) begin
            acc_next   = {1'b0, sum[WIDTH:1]};
            shreg_next = {sum[0], shreg[WIDTH-1:1]};
        end else begin
            acc_next   = {2'b00, acc[WIDTH-1:1]};
            shreg_next = {acc[0], shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide coprocessor; one bit per clock, result held
// until the next accepted operation completes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] muldiv,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] operand;

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shreg_upd;
    logic             q_bit;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div_op(op_q)),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .acc_next   (acc_next),
        .shreg_next (shreg_next),
        .q_bit      (q_bit)
    );

    assign shreg_upd = {shreg_next[WIDTH-1:1], shreg_next[0] | q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state; a start is honoured in IDLE and DONE, never in RUN.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                    last       = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result selection from the final iteration's outputs.
    always_comb begin
        res_c = shreg_upd;
        ovf_c = 1'b0;
        case (op_q)
            OP_MULL: begin
                res_c = shreg_upd;
                ovf_c = |acc_next[WIDTH-1:0];
            end
            OP_MULH: res_c = acc_next[WIDTH-1:0];
            OP_DIV:  res_c = shreg_upd;
            OP_MOD:  res_c = acc_next[WIDTH-1:0];
            default: res_c = shreg_upd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= OP_MULL;
            acc      <= '0;
            shreg    <= '0;
            operand  <= '0;
            muldiv   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                op_q    <= op_e'(op);
                acc     <= '0;
                shreg   <= a;
                operand <= b;
                cnt     <= '0;
            end else if (state == RUN) begin
                acc   <= acc_next;
                shreg <= shreg_upd;
                cnt   <= cnt + CNT_W'(1);
            end
            if (last) begin
                muldiv   <= res_c;
                overflow <= ovf_c;
                div_zero <= is_div_op(op_q) && (operand == '0);
            end
        end
    end

endmodule
